data_mem_unit: RTL

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/data_mem_unit.sv
// Word-organised data memory with byte/half/word stores, a combinational
// load port, alignment checking, a sticky error flag and load/store counters.
module data_mem_unit #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] rs2_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic        err_clr,
  output logic [31:0] mem_out,
  output logic        misaligned,
  output logic        err_sticky,
  output logic [15:0] ld_count,
  output logic [15:0] st_count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          store_ok;
  logic          load_ok;
  logic          err_set;
  logic          unused_addr;

  assign idx         = address[AW+1:2];
  assign off         = address[1:0];
  assign unused_addr = ^address[31:AW+2];

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // A simultaneous read+write is decoded purely as a store.
  always_comb begin
    misaligned = 1'b0;
    be         = 4'b0000;
    wdata      = rs2_data;
    if (mem_write) begin
      case (funct3)
        3'b000: begin
          be    = 4'b0001 << off;
          wdata = {4{rs2_data[7:0]}};
        end
        3'b001: begin
          misaligned = off[0];
          be         = off[1] ? 4'b1100 : 4'b0011;
          wdata      = {2{rs2_data[15:0]}};
        end
        3'b010: begin
          misaligned = (off != 2'b00);
          be         = 4'b1111;
        end
        default: misaligned = 1'b1;
      endcase
    end else if (mem_read) begin
      case (funct3)
        3'b000, 3'b100: misaligned = 1'b0;
        3'b001, 3'b101: misaligned = off[0];
        3'b010:         misaligned = (off != 2'b00);
        default:        misaligned = 1'b1;
      endcase
    end
  end

  assign store_ok = mem_write & ~misaligned;
  assign load_ok  = mem_read & ~mem_write & ~misaligned;
  assign err_set  = misaligned | (mem_read & mem_write);

  // Reads show the pre-write word; the reset gate keeps the output at zero
  // for the whole time reset is held.
  assign mem_out = reset ? 32'h0 : mem[idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (store_ok) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_count   <= 16'h0;
      st_count   <= 16'h0;
      err_sticky <= 1'b0;
    end else begin
      if (load_ok)  ld_count <= sat_inc(ld_count);
      if (store_ok) st_count <= sat_inc(st_count);
      if (err_set)      err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

endmodule
